// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state encodings, grant constants and default widths
package ram_arbiter_pkg;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] GNT_I  = 2'b01;
    localparam logic [1:0] GNT_D  = 2'b10;
endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: 2-way round-robin picker with a registered last-served bit
module ram_arb_rr
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic last_d;
    // under contention the port not served last wins; a lone request always wins
    always_comb begin
        gnt = req == 2'b11 ? (last_d ? GNT_I : GNT_D) :
              req[0] ? GNT_I : req[1] ? GNT_D : 2'b00;
    end
    // reset marks D as last served so the fetch port wins first
    always_ff @(posedge clk) begin
        if (rst) last_d <= 1'b1;
        else if (adv) last_d <= gnt[1];
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port RAM between a fetch port and a load/store port
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int aw = AW,
    parameter int dw = DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iram_req,
    input  logic [aw-1:0] iram_addr,
    output logic          iram_ack,
    output logic [dw-1:0] iram_dat,
    input  logic          dram_req,
    input  logic          dram_we,
    input  logic [3:0]    dram_sel,
    input  logic [aw-1:0] dram_addr,
    input  logic [dw-1:0] dram_dat_i,
    output logic          dram_ack,
    output logic [dw-1:0] dram_dat_o,
    output logic [aw-1:0] ram_addr,
    output logic [3:0]    ram_sel,
    output logic          ram_we,
    output logic [dw-1:0] ram_di,
    input  logic [dw-1:0] ram_doq
);
    logic [1:0]    state;
    logic [1:0]    gnt;
    logic          idle;
    logic          gi;
    logic          gd;
    logic [aw-1:0] addr_q;
    logic [3:0]    sel_q;
    logic [dw-1:0] di_q;
    ram_arb_rr u_rr (
        .clk (clk),
        .rst (rst),
        .req ({dram_req, iram_req}),
        .adv (gi | gd),
        .gnt (gnt)
    );
    // grants only happen in IDLE out of reset; RAM pins follow the winner, else hold
    always_comb begin
        idle       = state == IDLE && !rst;
        gi         = idle && gnt[0];
        gd         = idle && gnt[1];
        ram_addr   = gd ? dram_addr : gi ? iram_addr : addr_q;
        ram_sel    = gd ? dram_sel : gi ? 4'hF : sel_q;
        ram_di     = (gi || gd) ? dram_dat_i : di_q;
        ram_we     = gd && dram_we;
        iram_ack   = state == BUSY_I && !rst;
        dram_ack   = state == BUSY_D && !rst;
        iram_dat   = ram_doq;
        dram_dat_o = ram_doq;
    end
    // FSM plus hold registers that keep the RAM address stable during BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            sel_q  <= '0;
            di_q   <= '0;
        end else if (gi || gd) begin
            state  <= gd ? BUSY_D : BUSY_I;
            addr_q <= ram_addr;
            sel_q  <= ram_sel;
            di_q   <= ram_di;
        end else begin
            state  <= IDLE;
        end
    end
endmodule
